// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: turns byte/half/word requests into word-only
// memory accesses, using a two-cycle read-modify-write for sub-word stores.
module mem_access_unit #(
   parameter int ADDR_LIMIT = 4400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] RD     = 3'd1;
   localparam logic [2:0] WR     = 3'd2;
   localparam logic [2:0] RMW_RD = 3'd3;
   localparam logic [2:0] RMW_WR = 3'd4;

   logic [2:0]  state;
   logic [1:0]  q_size;
   logic        q_signed;
   logic [31:0] q_addr;
   logic [31:0] q_wdata;
   logic [31:0] merged;

   logic        req_err;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [31:0] st_merge;

   always_comb begin
      req_err = (req_size == 2'b11)
              | ((req_size == 2'b01) && req_addr[0])
              | ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              | (req_addr >= 32'(ADDR_LIMIT));
   end

   // Lane extraction for loads and lane insertion for sub-word stores.
   always_comb begin
      ld_byte  = mem_rdata[{q_addr[1:0], 3'b000} +: 8];
      ld_half  = q_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (q_size)
         2'b00:   ld_data = {{24{q_signed & ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = {{16{q_signed & ld_half[15]}}, ld_half};
         default: ld_data = mem_rdata;
      endcase
      st_merge = mem_rdata;
      if (q_size == 2'b00)
         st_merge[{q_addr[1:0], 3'b000} +: 8] = q_wdata[7:0];
      else
         st_merge[{q_addr[1], 4'b0000} +: 16] = q_wdata[15:0];
   end

   // Memory side depends only on state and the latched request.
   assign busy      = (state != IDLE);
   assign mem_read  = (state == RD) || (state == RMW_RD);
   assign mem_write = (state == WR) || (state == RMW_WR);
   assign mem_addr  = {q_addr[31:2], 2'b00};
   assign mem_wdata = (state == WR)     ? q_wdata :
                      (state == RMW_WR) ? merged  : 32'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         q_size    <= 2'b00;
         q_signed  <= 1'b0;
         q_addr    <= 32'h0;
         q_wdata   <= 32'h0;
         merged    <= 32'h0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_err) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= 32'h0;
                  end else begin
                     q_size   <= req_size;
                     q_signed <= req_signed;
                     q_addr   <= req_addr;
                     q_wdata  <= req_wdata;
                     if (!req_write)            state <= RD;
                     else if (req_size == 2'b10) state <= WR;
                     else                        state <= RMW_RD;
                  end
               end
            end
            RD: begin
               rsp_rdata <= ld_data;
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            WR: begin
               rsp_rdata <= 32'h0;
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            RMW_RD: begin
               merged <= st_merge;
               state  <= RMW_WR;
            end
            RMW_WR: begin
               rsp_rdata <= 32'h0;
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1100-word behavioural memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        busy, rsp_valid, rsp_err, mem_read, mem_write;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [0:1099];
   int          widx;

   mem_access_unit #(.ADDR_LIMIT(4400)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always_comb begin
      widx = int'(mem_addr[31:2]);
      mem_rdata = (mem_read && widx < 1100) ? mem[widx] : 32'h0;
   end

   always @(posedge clk)
      if (mem_write && widx < 1100) mem[widx] <= mem_wdata;

   // Issue one request and observe 8 cycles after the accept edge.
   task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int rdc, output int wrc,
                          output int bsy, output int vcnt, output logic err,
                          output logic [31:0] rdata, output logic [31:0] wdat);
      lat = -1; rdc = 0; wrc = 0; bsy = 0; vcnt = 0; err = 1'b0;
      rdata = 32'hx; wdat = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      for (int cyc = 1; cyc <= 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) req_valid = 1'b0;
         if (mem_read) rdc++;
         if (mem_write) begin wrc++; wdat = mem_wdata; end
         if (busy) bsy++;
         if (rsp_valid) begin
            vcnt++;
            if (lat < 0) begin lat = cyc; err = rsp_err; rdata = rsp_rdata; end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      #1;
      checks++;
      if ({busy, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 00000", {busy, rsp_valid, rsp_err, mem_read, mem_write});
      end
      checks++;
      if ({rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         failures++;
         $display("FAIL reset_data: got %h %h %h want zeros", rsp_rdata, mem_addr, mem_wdata);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_loads();
      logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
      logic        sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad  [5] = '{32'h09, 32'h09, 32'h0A, 32'h0A, 32'h08};
      logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
      int lat, rdc, wrc, bsy, vcnt; logic err; logic [31:0] rdata, wdat;
      mem[2] = 32'h8899AABB;
      for (int i = 0; i < 5; i++) begin
         run_req(1'b0, sz[i], sg[i], ad[i], 32'h0, lat, rdc, wrc, bsy, vcnt, err, rdata, wdat);
         checks++;
         if (rdata !== exp[i]) begin
            failures++; $display("FAIL load%0d_data: got %h want %h", i, rdata, exp[i]);
         end
         checks++;
         if (lat != 2 || vcnt != 1 || err !== 1'b0) begin
            failures++; $display("FAIL load%0d_timing: lat %0d pulses %0d err %b want 2 1 0", i, lat, vcnt, err);
         end
         checks++;
         if (rdc != 1 || wrc != 0 || bsy != 1) begin
            failures++; $display("FAIL load%0d_strobes: rd %0d wr %0d busy %0d want 1 0 1", i, rdc, wrc, bsy);
         end
      end
   endtask

   task automatic test_sub_stores();
      logic [1:0]  sz  [2] = '{2'b00, 2'b01};
      logic [31:0] ad  [2] = '{32'h0A, 32'h08};
      logic [31:0] wd  [2] = '{32'hFFFFFF5A, 32'hFFFF1234};
      logic [31:0] exp [2] = '{32'h885AAABB, 32'h88991234};
      int lat, rdc, wrc, bsy, vcnt; logic err; logic [31:0] rdata, wdat;
      for (int i = 0; i < 2; i++) begin
         mem[2] = 32'h8899AABB;
         run_req(1'b1, sz[i], 1'b0, ad[i], wd[i], lat, rdc, wrc, bsy, vcnt, err, rdata, wdat);
         checks++;
         if (wdat !== exp[i] || mem[2] !== exp[i]) begin
            failures++; $display("FAIL rmw%0d_data: wdata %h mem %h want %h", i, wdat, mem[2], exp[i]);
         end
         checks++;
         if (lat != 3 || vcnt != 1 || err !== 1'b0 || rdata !== 32'h0) begin
            failures++; $display("FAIL rmw%0d_rsp: lat %0d pulses %0d err %b rdata %h want 3 1 0 0", i, lat, vcnt, err, rdata);
         end
         checks++;
         if (rdc != 1 || wrc != 1 || bsy != 2) begin
            failures++; $display("FAIL rmw%0d_strobes: rd %0d wr %0d busy %0d want 1 1 2", i, rdc, wrc, bsy);
         end
      end
   endtask

   task automatic test_errors();
      logic [1:0]  sz [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
      logic        wr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad [4] = '{32'h09, 32'h06, 32'd4400, 32'h08};
      int lat, rdc, wrc, bsy, vcnt; logic err; logic [31:0] rdata, wdat;
      for (int i = 0; i < 4; i++) begin
         run_req(wr[i], sz[i], 1'b0, ad[i], 32'h12345678, lat, rdc, wrc, bsy, vcnt, err, rdata, wdat);
         checks++;
         if (lat != 1 || vcnt != 1 || err !== 1'b1 || rdata !== 32'h0) begin
            failures++; $display("FAIL err%0d_rsp: lat %0d pulses %0d err %b rdata %h want 1 1 1 0", i, lat, vcnt, err, rdata);
         end
         checks++;
         if (rdc != 0 || wrc != 0 || bsy != 0) begin
            failures++; $display("FAIL err%0d_strobes: rd %0d wr %0d busy %0d want 0 0 0", i, rdc, wrc, bsy);
         end
      end
      // Last word below the limit is legal.
      mem[1099] = 32'h0BADC0DE;
      run_req(1'b0, 2'b10, 1'b0, 32'd4396, 32'h0, lat, rdc, wrc, bsy, vcnt, err, rdata, wdat);
      checks++;
      if (lat != 2 || err !== 1'b0 || rdata !== 32'h0BADC0DE) begin
         failures++; $display("FAIL limit_lw: lat %0d err %b rdata %h want 2 0 0badc0de", lat, err, rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] obs_v = 4'h0, obs_b = 4'h0, obs_r = 4'h0, obs_w = 4'h0;
      logic [31:0] rd4 = 32'h0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      @(posedge clk);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         obs_v[cyc-1] = rsp_valid; obs_b[cyc-1] = busy;
         obs_r[cyc-1] = mem_read;  obs_w[cyc-1] = mem_write;
         if (cyc == 4) rd4 = rsp_rdata;
         if (cyc == 1) begin req_write = 1'b0; req_wdata = 32'h0; end
         if (cyc == 3) req_valid = 1'b0;
      end
      checks++;
      if (obs_v !== 4'b1010 || obs_b !== 4'b0101) begin
         failures++; $display("FAIL b2b_timing: valid %b busy %b want 1010 0101", obs_v, obs_b);
      end
      checks++;
      if (obs_w !== 4'b0001 || obs_r !== 4'b0100) begin
         failures++; $display("FAIL b2b_strobes: wr %b rd %b want 0001 0100", obs_w, obs_r);
      end
      checks++;
      if (rd4 !== 32'hDEADBEEF || mem[4] !== 32'hDEADBEEF) begin
         failures++; $display("FAIL b2b_data: rdata %h mem %h want deadbeef", rd4, mem[4]);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      mem[2] = 32'h8899AABB;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h08; req_wdata = 32'h77;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || mem_read !== 1'b1) begin
         failures++; $display("FAIL rst_mid_pre: busy %b rd %b want 1 1", busy, mem_read);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, rsp_valid, rsp_err, mem_read, mem_write} !== 5'b0 ||
          {rsp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
         failures++; $display("FAIL rst_mid_outputs: ctrl %b data %h %h %h want zeros",
                              {busy, rsp_valid, rsp_err, mem_read, mem_write}, rsp_rdata, mem_addr, mem_wdata);
      end
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         if (cyc == 2) reset = 1'b0;
         if (mem_write || rsp_valid) seen++;
      end
      checks++;
      if (seen != 0 || mem[2] !== 32'h8899AABB) begin
         failures++; $display("FAIL rst_mid_mem: stray strobes %0d mem %h want 0 8899aabb", seen, mem[2]);
      end
   endtask

   initial begin
      for (int i = 0; i < 1100; i++) mem[i] = 32'h0;
      test_reset();
      test_loads();
      test_sub_stores();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
